// File: rtl/dmem_scan_display.sv
// -----------------------------------------------------------------------------
// dmem_scan_display
//
// Walks a window of data-memory words [START_ADDR..END_ADDR] through the read
// port of the dual-port BRAM and presents each word to the seven-segment
// controller. Scanning is armed once by the processor's instruction-done flag
// and then runs until reset.
//
// State sequence per word:  ISSUE -> WAIT (READ_LATENCY) -> HOLD -> ADVANCE
//
//   ISSUE    one cycle with the BRAM read enable high at the current address
//   WAIT     READ_LATENCY cycles; read data is captured on the last one
//   HOLD     display hold; behaviour set by mode_in (auto / step / freeze)
//   ADVANCE  one cycle; moves to the next address, wrapping at END_ADDR
//
// In auto mode the display period per word is 1 + READ_LATENCY + HOLD_CYCLES
// cycles. The ADVANCE cycle is counted as the last cycle of the hold, so HOLD
// itself lasts HOLD_CYCLES-1 cycles (minimum one cycle, so HOLD_CYCLES=1
// behaves like HOLD_CYCLES=2).
//
// A change of mode_in while in HOLD restarts the hold counter. The cycle in
// which the change is seen is itself a hold cycle, so returning to auto gives
// a full HOLD_CYCLES of HOLD before ADVANCE.
//
// val_out is combinational from the captured address/data pair and
// show_full_in, so toggling show_full_in never triggers a BRAM re-read.
// The address shown in split mode is the one the displayed data was read
// from, not the address currently being fetched, so the pair stays coherent.
// -----------------------------------------------------------------------------
module dmem_scan_display #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int HOLD_CYCLES  = 100000,
  parameter int START_ADDR   = 0,
  parameter int END_ADDR     = 9
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  arm_in,
  input  logic [1:0]            mode_in,
  input  logic                  step_in,
  input  logic                  show_full_in,
  output logic                  mem_en_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [31:0]           val_out,
  output logic                  val_valid_out,
  output logic                  busy_out,
  output logic                  wrap_out
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  // Latency counter runs 0 .. READ_LATENCY-1 inside WAIT.
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  // Hold counter runs 0 .. HOLD_CYCLES-2 inside HOLD (ADVANCE is the last
  // cycle of the hold period).
  localparam int HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int HOLD_LAST_I = (HOLD_CYCLES >= 2) ? (HOLD_CYCLES - 2) : 0;
  // Widths of the address and data fields that reach the 32-bit display word.
  localparam int AW16 = (ADDR_WIDTH < 16) ? ADDR_WIDTH : 16;
  localparam int DW32 = (DATA_WIDTH < 32) ? DATA_WIDTH : 32;

  localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(READ_LATENCY - 1);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(HOLD_LAST_I);
  localparam logic [ADDR_WIDTH-1:0] START_A   = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] END_A     = ADDR_WIDTH'(END_ADDR);

  localparam logic [1:0] MODE_AUTO = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_ADVANCE = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   addr_r;       // address being fetched
  logic [ADDR_WIDTH-1:0]   disp_addr_r;  // address of the displayed word
  logic [DATA_WIDTH-1:0]   data_r;       // displayed word
  logic [LAT_W-1:0]        lat_cnt_r;
  logic [HOLD_W-1:0]       hold_cnt_r;
  logic [1:0]              mode_q_r;     // mode_in from the previous cycle
  logic                    mem_en_r;
  logic                    valid_r;
  logic                    busy_r;
  logic                    wrap_r;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                    mode_chg_s;
  logic                    at_end_s;
  logic [15:0]             addr16_s;
  logic [31:0]             data32_s;
  logic [31:0]             val_s;

  assign mode_chg_s = (mode_in != mode_q_r);
  assign at_end_s   = (addr_r == END_A);

  // Scan controller: state, counters, captured word and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r     <= ST_IDLE;
      addr_r      <= START_A;
      disp_addr_r <= START_A;
      data_r      <= '0;
      lat_cnt_r   <= '0;
      hold_cnt_r  <= '0;
      mode_q_r    <= 2'b00;
      mem_en_r    <= 1'b0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      wrap_r      <= 1'b0;
    end else begin
      // Single-cycle strobes default low; the state that needs them sets them.
      mode_q_r <= mode_in;
      mem_en_r <= 1'b0;
      wrap_r   <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          // Armed once; arm_in is not looked at again until reset.
          if (arm_in) begin
            state_r  <= ST_ISSUE;
            mem_en_r <= 1'b1;
            busy_r   <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          lat_cnt_r <= '0;
          state_r   <= ST_WAIT;
        end

        ST_WAIT: begin
          if (lat_cnt_r == LAT_LAST) begin
            // BRAM output is valid in this cycle; capture it with its address.
            data_r      <= mem_data_in;
            disp_addr_r <= addr_r;
            valid_r     <= 1'b1;
            hold_cnt_r  <= '0;
            state_r     <= ST_HOLD;
          end else begin
            lat_cnt_r   <= lat_cnt_r + LAT_W'(1);
          end
        end

        ST_HOLD: begin
          case (mode_in)
            MODE_AUTO: begin
              if (mode_chg_s) begin
                // Just switched into auto: start a fresh hold period.
                hold_cnt_r <= '0;
              end else if (hold_cnt_r >= HOLD_LAST) begin
                hold_cnt_r <= '0;
                wrap_r     <= at_end_s;
                state_r    <= ST_ADVANCE;
              end else begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
              end
            end

            MODE_STEP: begin
              // Counter parked at zero; only a step pulse moves on.
              hold_cnt_r <= '0;
              if (step_in) begin
                wrap_r  <= at_end_s;
                state_r <= ST_ADVANCE;
              end else begin
                state_r <= ST_HOLD;
              end
            end

            default: begin
              // Freeze (and the reserved encoding): counter paused, steps
              // ignored, no reads.
              if (mode_chg_s) begin
                hold_cnt_r <= '0;
              end else begin
                hold_cnt_r <= hold_cnt_r;
              end
            end
          endcase
        end

        ST_ADVANCE: begin
          if (at_end_s) begin
            addr_r <= START_A;
          end else begin
            addr_r <= addr_r + ADDR_WIDTH'(1);
          end
          mem_en_r <= 1'b1;
          state_r  <= ST_ISSUE;
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Display word: split {address, low data half} or the full data word,
  // forced to zero until the first word has been captured.
  always_comb begin
    addr16_s             = 16'd0;
    addr16_s[AW16-1:0]   = disp_addr_r[AW16-1:0];
    data32_s             = 32'd0;
    data32_s[DW32-1:0]   = data_r[DW32-1:0];
    if (!valid_r) begin
      val_s = 32'd0;
    end else if (show_full_in) begin
      val_s = data32_s;
    end else begin
      val_s = {addr16_s, data32_s[15:0]};
    end
  end

  assign mem_en_out    = mem_en_r;
  assign mem_addr_out  = addr_r;
  assign val_out       = val_s;
  assign val_valid_out = valid_r;
  assign busy_out      = busy_r;
  assign wrap_out      = wrap_r;

endmodule
